// File: rtl/riscv_seq_divider.sv
// Radix-2 restoring sequential divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; sign fix-up and result select happen in a single FINISH cycle.
module riscv_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [6:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             flush_i,
    input  logic             ex_ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, DONE} state_t;

    state_t           state_q, state_d;
    logic             signed_q, rem_q, sign_a_q, sign_b_q, b_zero_q;
    logic [WIDTH-1:0] quo_q, divisor_q, rem_acc_q, result_q;
    logic [CNT_W-1:0] cnt_q;

    logic             op_valid, accept, last_step, neg_quo, neg_rem;
    logic [WIDTH:0]   shifted, trial;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_valid  = (operator_i[6:2] == 5'b01100);
    assign accept    = enable_i && (state_q == IDLE) && op_valid && !flush_i;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Trial subtraction is one bit wider so its MSB doubles as the borrow flag.
    assign shifted = {rem_acc_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_q};

    // Divide-by-zero leaves an all-ones quotient, which must not be negated.
    assign neg_quo = signed_q && !b_zero_q && (sign_a_q ^ sign_b_q);
    assign neg_rem = signed_q && sign_a_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)     state_d = DIVIDE;
            DIVIDE:  if (last_step)  state_d = FINISH;
            FINISH:                  state_d = DONE;
            DONE:    if (ex_ready_i) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signed_q  <= 1'b0;
            rem_q     <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            quo_q     <= '0;
            divisor_q <= '0;
            rem_acc_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            signed_q  <= operator_i[0];
            rem_q     <= operator_i[1];
            sign_a_q  <= op_a_i[WIDTH-1];
            sign_b_q  <= op_b_i[WIDTH-1];
            b_zero_q  <= (op_b_i == '0);
            quo_q     <= cond_neg(op_a_i, operator_i[0] && op_a_i[WIDTH-1]);
            divisor_q <= cond_neg(op_b_i, operator_i[0] && op_b_i[WIDTH-1]);
            rem_acc_q <= '0;
            cnt_q     <= '0;
        end else if (state_q == DIVIDE) begin
            rem_acc_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_q     <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_q     <= cnt_q + CNT_W'(1);
        end else if ((state_q == FINISH) && !flush_i) begin
            result_q  <= rem_q ? cond_neg(rem_acc_q, neg_rem) : cond_neg(quo_q, neg_quo);
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Self-checking bench for riscv_seq_divider: directed corner cases plus random
// operations compared with an arithmetic reference model.
module tb_riscv_seq_divider;

    localparam logic [6:0] ALU_DIVU = 7'b0110000;
    localparam logic [6:0] ALU_DIV  = 7'b0110001;
    localparam logic [6:0] ALU_REMU = 7'b0110010;
    localparam logic [6:0] ALU_REM  = 7'b0110011;
    localparam logic [6:0] ALU_ADD  = 7'b0011000;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [6:0]  operator_i;
    logic [31:0] op_a_i, op_b_i;
    logic        flush_i, ex_ready_i;
    logic        ready_o, valid_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    riscv_seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_i  (enable_i),
        .operator_i(operator_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .flush_i   (flush_i),
        .ex_ready_i(ex_ready_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Issues one request, scrambles operands after acceptance, waits for valid_o.
    task automatic do_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, output logic [31:0] res, output int lat,
                         output logic post_ready);
        @(negedge clk);
        enable_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b; ex_ready_i = rdy;
        @(posedge clk);
        @(negedge clk);
        enable_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); lat++; #1;
            if (valid_o) break;
        end
        res = result_o;
        post_ready = 1'b0;
        if (rdy) begin
            @(posedge clk); #1;
            post_ready = ready_o && !valid_o;
        end
    endtask

    task automatic test_reset();
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result_o); end
    endtask

    task automatic test_directed();
        logic [6:0]  ops [11] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REM, ALU_REMU, ALU_DIVU, ALU_DIV,
                                  ALU_REM, ALU_DIV, ALU_REM, ALU_REMU};
        logic [31:0] as  [11] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h1234_5678,
                                  32'h1234_5678, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs  [11] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [11] = '{32'd14, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'h1234_5678};
        logic [31:0] res;
        int lat;
        logic pr;
        for (int i = 0; i < 11; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b1, res, lat, pr);
            checks++; if (res !== exp[i]) begin failures++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, exp[i]); end
            checks++; if (lat != LAT) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
            checks++; if (pr !== 1'b1) begin failures++; $display("FAIL directed_ready_after[%0d] got=%b want=1", i, pr); end
        end
    endtask

    task automatic test_random();
        logic [6:0]  opset [4] = '{ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};
        logic [6:0]  op;
        logic [31:0] a, b, res, exp;
        int lat;
        logic pr;
        for (int i = 0; i < 24; i++) begin
            op = opset[$urandom_range(0, 3)];
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF);
                default: b = 32'($urandom);
            endcase
            exp = model(op, a, b);
            do_op(op, a, b, 1'b1, res, lat, pr);
            checks++; if (res !== exp) begin failures++; $display("FAIL random_result op=%b a=%h b=%h got=%h want=%h", op, a, b, res, exp); end
            checks++; if (lat != LAT) begin failures++; $display("FAIL random_latency got=%0d want=%0d", lat, LAT); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] res;
        int lat;
        logic pr;
        do_op(ALU_DIV, 32'hFFFF_FC18, 32'd7, 1'b0, res, lat, pr);
        checks++; if (res !== 32'hFFFF_FF72) begin failures++; $display("FAIL hold_result got=%h want=ffffff72", res); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (valid_o !== 1'b1 || result_o !== 32'hFFFF_FF72) begin
                failures++; $display("FAIL hold_stable[%0d] valid=%b result=%h want valid=1 result=ffffff72", i, valid_o, result_o);
            end
        end
        @(negedge clk); ex_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++; $display("FAIL hold_handshake ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
        end
    endtask

    task automatic test_ignore();
        logic [31:0] prev;
        int lat;
        logic seen;
        prev = result_o;
        @(negedge clk); enable_i = 1'b1; operator_i = ALU_ADD; op_a_i = 32'd5; op_b_i = 32'd1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o || !ready_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || result_o !== prev) begin
            failures++; $display("FAIL ignore_alu_add busy_seen=%b result=%h want busy_seen=0 result=%h", seen, result_o, prev);
        end
        // Second request held high while busy must not disturb the first.
        @(negedge clk); operator_i = ALU_DIVU; op_a_i = 32'd1000; op_b_i = 32'd10; ex_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk); operator_i = ALU_REM; op_a_i = 32'd77; op_b_i = 32'd5;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); lat++; #1;
            if (valid_o) break;
        end
        checks++; if (result_o !== 32'd100 || lat != LAT) begin
            failures++; $display("FAIL ignore_busy result=%h lat=%0d want result=00000064 lat=%0d", result_o, lat, LAT);
        end
        @(negedge clk); enable_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL ignore_ready_after got=%b want=1", ready_o); end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        int lat;
        logic seen, pr;
        prev = result_o;
        @(negedge clk); enable_i = 1'b1; operator_i = ALU_DIV; op_a_i = 32'd999; op_b_i = 32'd3;
        @(posedge clk);
        @(negedge clk); enable_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_divide ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
        end
        @(negedge clk); flush_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0 || result_o !== prev) begin
            failures++; $display("FAIL flush_no_result valid_seen=%b result=%h want valid_seen=0 result=%h", seen, result_o, prev);
        end
        // Request coincident with flush in IDLE is dropped.
        @(negedge clk); enable_i = 1'b1; flush_i = 1'b1;
        @(negedge clk); enable_i = 1'b0; flush_i = 1'b0;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_same_cycle_accept ready=%b want=1", ready_o); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_same_cycle_valid got=%b want=0", seen); end
        // Flush in DONE drops valid even with ex_ready_i low.
        do_op(ALU_DIVU, 32'd50, 32'd5, 1'b0, res, lat, pr);
        checks++; if (res !== 32'd10) begin failures++; $display("FAIL flush_done_result got=%h want=0000000a", res); end
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd10) begin
            failures++; $display("FAIL flush_done valid=%b ready=%b result=%h want 0 1 0000000a", valid_o, ready_o, result_o);
        end
        @(negedge clk); flush_i = 1'b0; ex_ready_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        int low_run, runs;
        logic prev_ready, double_high;
        @(negedge clk); enable_i = 1'b1; operator_i = ALU_DIVU; op_a_i = 32'd300; op_b_i = 32'd3; ex_ready_i = 1'b1;
        low_run = 0; runs = 0; prev_ready = 1'b1; double_high = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                if (prev_ready) double_high = 1'b1;
                if (low_run > 0) begin
                    runs++;
                    checks++; if (low_run != 34) begin failures++; $display("FAIL b2b_busy_cycles got=%0d want=34", low_run); end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            if (valid_o) begin
                checks++; if (result_o !== 32'd100) begin failures++; $display("FAIL b2b_result got=%h want=00000064", result_o); end
            end
            prev_ready = ready_o;
        end
        checks++; if (runs < 2 || double_high) begin
            failures++; $display("FAIL b2b_pattern runs=%0d idle_twice=%b want runs>=2 idle_twice=0", runs, double_high);
        end
        @(negedge clk); enable_i = 1'b0;
        repeat (40) @(posedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat;
        logic pr, seen;
        @(negedge clk); enable_i = 1'b1; operator_i = ALU_REM; op_a_i = 32'd12345; op_b_i = 32'd97;
        @(posedge clk);
        @(negedge clk); enable_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b want=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b want=0", valid_o); end
        checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL async_reset_result got=%h want=0", result_o); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL async_reset_no_result got=%b want=0", seen); end
        do_op(ALU_DIVU, 32'd9, 32'd3, 1'b1, res, lat, pr);
        checks++; if (res !== 32'd3 || lat != LAT) begin
            failures++; $display("FAIL post_reset_op result=%h lat=%0d want 00000003 %0d", res, lat, LAT);
        end
    endtask

    initial begin
        rst = 1'b1; enable_i = 1'b0; operator_i = 7'd0; op_a_i = 32'd0; op_b_i = 32'd0;
        flush_i = 1'b0; ex_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
